// File: rtl/kdtree_pkg.sv
// Shared constants, node-word field layout and the loader state enum for the
// kd-tree node loader.
package kdtree_pkg;

  localparam int DATA_WIDTH    = 55;
  localparam int STORAGE_WIDTH = 22;
  localparam int ELEM_WIDTH    = 11;
  localparam int PATCH_ELEMS   = 5;

  // Node word = {median (signed), index}
  localparam int IDX_LSB = 0;
  localparam int IDX_MSB = ELEM_WIDTH - 1;
  localparam int MED_LSB = ELEM_WIDTH;
  localparam int MED_MSB = STORAGE_WIDTH - 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DONE = 2'd2
  } loader_state_e;

endpackage

// File: rtl/node_wen_decoder.sv
// Binary node counter to one-hot write-enable decoder; all zeros when en=0.
module node_wen_decoder #(
  parameter int NUM_NODES = 31,
  parameter int CNT_W     = 5
) (
  input  logic                 en,
  input  logic [CNT_W-1:0]     idx,
  output logic [NUM_NODES-1:0] onehot
);

  always_comb begin
    onehot = '0;
    for (int i = 0; i < NUM_NODES; i++) begin
      onehot[i] = en && (idx == CNT_W'(i));
    end
  end

endmodule

// File: rtl/kdtree_node_loader.sv
// Streams NUM_NODES node words into the tree, one registered one-hot write per
// accepted word. Define KDTREE_LOADER_IDX_CHECK_EN to enable index range checking.
//
// Handshake: a word transfers on a rising edge where in_valid && in_ready;
// in_ready is high only in LOAD, and in_valid may be held across gaps.
module kdtree_node_loader #(
  parameter int NUM_NODES     = 31,
  parameter int STORAGE_WIDTH = 22,
  parameter int PATCH_ELEMS   = 5
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic                     abort,
  input  logic                     in_valid,
  input  logic [STORAGE_WIDTH-1:0] in_data,
  output logic                     in_ready,
  output logic [NUM_NODES-1:0]     wen,
  output logic [STORAGE_WIDTH-1:0] wdata,
  output logic                     busy,
  output logic                     done,
  output logic                     err,
  output logic [1:0]               state_dbg
);

  import kdtree_pkg::*;

  localparam int CNT_W = (NUM_NODES > 1) ? $clog2(NUM_NODES) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_NODES - 1);

  loader_state_e state_q, state_d;
  logic [CNT_W-1:0]         cnt_q;
  logic [NUM_NODES-1:0]     wen_q;
  logic [NUM_NODES-1:0]     wen_d;
  logic [STORAGE_WIDTH-1:0] wdata_q;
  logic [STORAGE_WIDTH-1:0] word_w;
  logic                     hs;
  logic                     start_load;

  // A patch must hold at least one element and fit in the index field.
  if (PATCH_ELEMS < 1 || PATCH_ELEMS > (1 << ELEM_WIDTH)) begin : g_bad_patch_elems
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    hs         = 1'b0;
    start_load = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d    = ST_LOAD;
          start_load = 1'b1;
        end
      end
      ST_LOAD: begin
        if (in_valid) begin
          hs = 1'b1;
          if (cnt_q == LAST_CNT) state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (start) begin
          state_d    = ST_LOAD;
          start_load = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // abort beats both a pending handshake and a start
    if (abort) begin
      state_d    = ST_IDLE;
      hs         = 1'b0;
      start_load = 1'b0;
    end
  end

  node_wen_decoder #(
    .NUM_NODES (NUM_NODES),
    .CNT_W     (CNT_W)
  ) u_wen_dec (
    .en     (hs),
    .idx    (cnt_q),
    .onehot (wen_d)
  );

`ifdef KDTREE_LOADER_IDX_CHECK_EN
  logic idx_bad;
  logic err_q;

  assign idx_bad = in_data[IDX_MSB:IDX_LSB] >= ELEM_WIDTH'(PATCH_ELEMS);
  assign word_w  = idx_bad ? {in_data[STORAGE_WIDTH-1:MED_LSB], {ELEM_WIDTH{1'b0}}} : in_data;

  always_ff @(posedge clk) begin
    if (!rst_n)          err_q <= 1'b0;
    else if (start_load) err_q <= 1'b0;
    else if (hs && idx_bad) err_q <= 1'b1;
  end

  assign err = err_q;
`else
  assign word_w = in_data;
  assign err    = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      wen_q   <= '0;
      wdata_q <= '0;
    end else begin
      wen_q <= wen_d;
      if (hs) wdata_q <= word_w;
      if (abort || start_load) cnt_q <= '0;
      else if (hs)             cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign wen       = wen_q;
  assign wdata     = wdata_q;
  assign in_ready  = (state_q == ST_LOAD);
  assign busy      = (state_q == ST_LOAD);
  assign done      = (state_q == ST_DONE);
  assign state_dbg = state_q;

endmodule

// File: tb/tb_kdtree_node_loader.sv
// Directed, table-driven bench for kdtree_node_loader (honours
// KDTREE_LOADER_IDX_CHECK_EN when defined for the build).
module tb_kdtree_node_loader;

  localparam int N  = 31;
  localparam int SW = 22;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic          abort;
  logic          in_valid;
  logic [SW-1:0] in_data;
  logic          in_ready;
  logic [N-1:0]  wen;
  logic [SW-1:0] wdata;
  logic          busy;
  logic          done;
  logic          err;
  logic [1:0]    state_dbg;

  int checks = 0;
  int errors = 0;
  logic [SW-1:0] exp_q[$];
  logic          model_err;

  kdtree_node_loader #(
    .NUM_NODES     (N),
    .STORAGE_WIDTH (SW),
    .PATCH_ELEMS   (5)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .abort     (abort),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .wen       (wen),
    .wdata     (wdata),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .state_dbg (state_dbg)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          start;
    logic          abort;
    logic          in_valid;
    logic [SW-1:0] in_data;
    logic [N-1:0]  exp_wen;
    logic [SW-1:0] exp_wdata;
    logic          exp_ready;
    logic          exp_busy;
    logic          exp_done;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [SW-1:0] exp_word(input logic [SW-1:0] w);
`ifdef KDTREE_LOADER_IDX_CHECK_EN
    if (w[10:0] >= 11'd5) return {w[21:11], 11'd0};
`endif
    return w;
  endfunction

  function automatic logic word_sets_err(input logic [SW-1:0] w);
`ifdef KDTREE_LOADER_IDX_CHECK_EN
    return w[10:0] >= 11'd5;
`else
    return 1'b0;
`endif
  endfunction

  task automatic idle_inputs();
    start    = 1'b0;
    abort    = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
  endtask

  // Load cnt words starting from an active LOAD state; indices kept below 5.
  task automatic load_words(input int cnt, input logic [SW-1:0] base);
    for (int k = 0; k < cnt; k++) begin
      in_valid = 1'b1;
      in_data  = base | SW'(k % 5);
      tick();
    end
    in_valid = 1'b0;
  endtask

  initial begin
    logic [SW-1:0] w;
    logic [SW-1:0] last_w;

    vecs[0] = '{1'b0, 1'b0, 1'b1, 22'h000123, 31'h0, 22'h000000, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{1'b1, 1'b0, 1'b0, 22'h000000, 31'h0, 22'h000000, 1'b1, 1'b1, 1'b0};
    vecs[2] = '{1'b0, 1'b0, 1'b1, 22'h000801, 31'h1, 22'h000801, 1'b1, 1'b1, 1'b0};
    vecs[3] = '{1'b0, 1'b0, 1'b0, 22'h000AAA, 31'h0, 22'h000801, 1'b1, 1'b1, 1'b0};
    vecs[4] = '{1'b0, 1'b0, 1'b0, 22'h000BBB, 31'h0, 22'h000801, 1'b1, 1'b1, 1'b0};
    vecs[5] = '{1'b0, 1'b0, 1'b1, 22'h000802, 31'h2, 22'h000802, 1'b1, 1'b1, 1'b0};
    vecs[6] = '{1'b1, 1'b0, 1'b0, 22'h000000, 31'h0, 22'h000802, 1'b1, 1'b1, 1'b0};
    vecs[7] = '{1'b0, 1'b1, 1'b0, 22'h000000, 31'h0, 22'h000802, 1'b0, 1'b0, 1'b0};

    // clock/reset
    idle_inputs();
    rst_n = 1'b0;
    tick();
    tick();
    check("rst_wen", 32'(wen), 32'h0);
    check("rst_wdata", 32'(wdata), 32'h0);
    check("rst_ready", 32'(in_ready), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_done", 32'(done), 32'h0);
    check("rst_err", 32'(err), 32'h0);
    check("rst_state", 32'(state_dbg), 32'h0);
    rst_n = 1'b1;

    // idle-ignore, start, backpressure gaps, start-in-load ignored, abort
    for (int i = 0; i < 8; i++) begin
      start    = vecs[i].start;
      abort    = vecs[i].abort;
      in_valid = vecs[i].in_valid;
      in_data  = vecs[i].in_data;
      tick();
      check($sformatf("vec%0d_wen", i), 32'(wen), 32'(vecs[i].exp_wen));
      check($sformatf("vec%0d_wdata", i), 32'(wdata), 32'(vecs[i].exp_wdata));
      check($sformatf("vec%0d_ready", i), 32'(in_ready), 32'(vecs[i].exp_ready));
      check($sformatf("vec%0d_busy", i), 32'(busy), 32'(vecs[i].exp_busy));
      check($sformatf("vec%0d_done", i), 32'(done), 32'(vecs[i].exp_done));
    end
    idle_inputs();

    // full back-to-back load of 31 words
    model_err = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("full_busy_start", 32'(busy), 32'h1);
    for (int k = 0; k < N; k++) begin
      in_valid = 1'b1;
      in_data  = 22'h000800 + SW'(k + 1);
      exp_q.push_back(exp_word(in_data));
      if (word_sets_err(in_data)) model_err = 1'b1;
      tick();
      check($sformatf("full_wen%0d", k), 32'(wen), 32'(1) << k);
      w = exp_q.pop_front();
      last_w = w;
      check($sformatf("full_wdata%0d", k), 32'(wdata), 32'(w));
      check($sformatf("full_ready%0d", k), 32'(in_ready), (k < N - 1) ? 32'h1 : 32'h0);
      check($sformatf("full_err%0d", k), 32'(err), 32'(model_err));
    end
    in_valid = 1'b0;
    check("full_done", 32'(done), 32'h1);
    check("full_busy_end", 32'(busy), 32'h0);
    tick();
    check("full_wen_after", 32'(wen), 32'h0);
    check("full_wdata_hold", 32'(wdata), 32'(last_w));
    check("full_done_level", 32'(done), 32'h1);
    check("full_state_done", 32'(state_dbg), 32'h2);

    // restart from DONE clears err; abort with handshake at cnt=7
    start = 1'b1;
    tick();
    start = 1'b0;
    check("restart_busy", 32'(busy), 32'h1);
    check("restart_err", 32'(err), 32'h0);
    load_words(7, 22'h001000);
    check("pre_abort_wdata", 32'(wdata), 32'h001001);
    abort    = 1'b1;
    in_valid = 1'b1;
    in_data  = 22'h3FFFFF;
    tick();
    idle_inputs();
    check("abort_wen", 32'(wen), 32'h0);
    check("abort_wdata", 32'(wdata), 32'h001001);
    check("abort_ready", 32'(in_ready), 32'h0);
    check("abort_state", 32'(state_dbg), 32'h0);
    tick();
    check("abort_wen_next", 32'(wen), 32'h0);
    start = 1'b1;
    tick();
    start    = 1'b0;
    in_valid = 1'b1;
    in_data  = 22'h002002;
    tick();
    in_valid = 1'b0;
    check("reload_wen0", 32'(wen), 32'h1);
    check("reload_wdata", 32'(wdata), 32'h002002);

    // reset mid-load at cnt=12
    abort = 1'b1;
    tick();
    abort = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    load_words(12, 22'h000800);
    rst_n    = 1'b0;
    in_valid = 1'b1;
    in_data  = 22'h000804;
    tick();
    check("mrst_wen", 32'(wen), 32'h0);
    check("mrst_wdata", 32'(wdata), 32'h0);
    check("mrst_ready", 32'(in_ready), 32'h0);
    check("mrst_busy", 32'(busy), 32'h0);
    check("mrst_done", 32'(done), 32'h0);
    check("mrst_err", 32'(err), 32'h0);
    rst_n    = 1'b1;
    start    = 1'b1;
    in_valid = 1'b1;
    in_data  = 22'h000803;
    tick();
    start = 1'b0;
    check("post_rst_start_wen", 32'(wen), 32'h0);
    check("post_rst_busy", 32'(busy), 32'h1);
    tick();
    in_valid = 1'b0;
    check("post_rst_wen0", 32'(wen), 32'h1);
    check("post_rst_wdata", 32'(wdata), 32'h000803);

    // index range check
    abort = 1'b1;
    tick();
    abort = 1'b0;
    start = 1'b1;
    tick();
    start    = 1'b0;
    in_valid = 1'b1;
    in_data  = 22'b0000000001000000000111;
    tick();
`ifdef KDTREE_LOADER_IDX_CHECK_EN
    check("idx_err", 32'(err), 32'h1);
    check("idx_wdata", 32'(wdata), 32'h001000);
`else
    check("idx_err", 32'(err), 32'h0);
    check("idx_wdata", 32'(wdata), 32'h001007);
`endif
    in_data = 22'h000801;
    tick();
    in_valid = 1'b0;
    check("idx_err_sticky", 32'(err), 32'(word_sets_err(22'b0000000001000000000111)));
    check("idx_next_wen", 32'(wen), 32'h2);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("idx_err_cleared", 32'(err), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
